uart_ack_sender: RTL and testbench

UART transmitter with acknowledgement and retransmission for the external-communication path. It serialises one byte onto the GPIO transmit wire, then listens on the paired receive wire for the acknowledgement byte from the external FPGA. If the acknowledgement does not arrive within the timeout, it retransmits, up to a bounded count. It sits between the external-communication controller, which supplies the byte and the send strobe, and the board GPIO pins (the send-data/send-ack pair).

---
 rtl/uart_ack_sender_if.sv | 31 +++
 rtl/uart_ack_sender.sv | 278 +++++++++++++++++++++++++++
 tb/tb_uart_ack_sender.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_ack_sender_if.sv
// uart_ack_sender_if
// Handshake bundle between the external-communication controller and the
// acknowledged UART transmitter.
//   data_in  : byte to send, sampled when the request is accepted
//   send     : request strobe
//   ready    : transmitter idle, a request can be accepted
//   done     : one-cycle pulse, acknowledgement received
//   fail     : one-cycle pulse, retries exhausted
//   attempts : frames sent for the current byte
// Modports: master = controller side, slave = transmitter side.
interface uart_ack_sender_if #(
    parameter int UART_WIDTH = 8,
    parameter int ATT_W      = 3
);
    logic [UART_WIDTH-1:0] data_in;
    logic                  send;
    logic                  ready;
    logic                  done;
    logic                  fail;
    logic [ATT_W-1:0]      attempts;

    modport master (
        output data_in, send,
        input  ready, done, fail, attempts
    );

    modport slave (
        input  data_in, send,
        output ready, done, fail, attempts
    );
endinterface

// File: rtl/uart_ack_sender.sv
// uart_ack_sender
// Serialises one byte onto the GPIO send-data wire, then listens on the
// send-ack wire for the acknowledgement byte from the external FPGA. A
// missing acknowledgement triggers a retransmission of the latched byte, up
// to RETRANSMIT_COUNT extra frames.
// Ports:
//   clk  : single clock, posedge
//   rstN : synchronous active-low reset
//   bus  : controller handshake (data_in, send, ready, done, fail, attempts)
//   tx   : UART output, idles high
//   rx   : asynchronous UART input from the far end
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | ready high, waiting for an accepted send
// TX_START   | driving the start bit
// TX_DATA    | driving data bits, LSB first
// TX_STOP    | driving the stop bit
// WAIT_ACK   | timeout timer running, acknowledgement receiver armed
module uart_ack_sender #(
    parameter int                    CLK_FREQ         = 50_000_000,
    parameter int                    BAUD_RATE        = 230400,
    parameter int                    UART_WIDTH       = 8,
    parameter int                    RETRANSMIT_COUNT = 5,
    parameter int                    ACK_TIMEOUT      = 1,
    parameter logic [UART_WIDTH-1:0] ACK_BYTE         = UART_WIDTH'(8'b11001100)
) (
    input  logic              clk,
    input  logic              rstN,
    uart_ack_sender_if.slave  bus,
    output logic              tx,
    input  logic              rx
);

    localparam int BAUD_DIV    = CLK_FREQ / BAUD_RATE;
    localparam int HALF_DIV    = BAUD_DIV / 2;
    localparam int TIMEOUT_CYC = ACK_TIMEOUT * CLK_FREQ / 1000;
    localparam int BAUD_W      = $clog2(BAUD_DIV + 1);
    localparam int TMR_W       = $clog2(TIMEOUT_CYC + 1);
    localparam int BIT_W       = (UART_WIDTH > 1) ? $clog2(UART_WIDTH) : 1;
    localparam int ATT_W       = $clog2(RETRANSMIT_COUNT + 2);

    localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BAUD_W-1:0] HALF_LOAD = BAUD_W'(HALF_DIV - 1);
    localparam logic [TMR_W-1:0]  TMR_LOAD  = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(UART_WIDTH - 1);
    localparam logic [ATT_W-1:0]  ATT_ONE   = ATT_W'(1);
    localparam logic [ATT_W-1:0]  ATT_MAX   = ATT_W'(RETRANSMIT_COUNT + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_TX_START = 3'd1;
    localparam logic [2:0] S_TX_DATA  = 3'd2;
    localparam logic [2:0] S_TX_STOP  = 3'd3;
    localparam logic [2:0] S_WAIT_ACK = 3'd4;

    localparam logic [1:0] R_HUNT  = 2'd0;
    localparam logic [1:0] R_START = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;
    localparam logic [1:0] R_STOP  = 2'd3;

    logic [2:0]            state;
    logic                  send_r;
    logic [UART_WIDTH-1:0] data_r;
    logic [UART_WIDTH-1:0] data_lat;
    logic [UART_WIDTH-1:0] tx_shift;
    logic [BAUD_W-1:0]     tx_cnt;
    logic [BIT_W-1:0]      tx_bit;
    logic                  tx_q;
    logic [TMR_W-1:0]      tmr;
    logic [ATT_W-1:0]      attempts_q;
    logic                  done_q;
    logic                  fail_q;

    logic                  rx_meta;
    logic                  rx_sync;
    logic                  rx_prev;
    logic [1:0]            rx_state;
    logic [BAUD_W-1:0]     rx_cnt;
    logic [BIT_W-1:0]      rx_bit;
    logic [UART_WIDTH-1:0] rx_shift;

    logic                  rx_fall;
    logic                  ack_hit;
    logic                  timeout;

    assign rx_fall = rx_prev & ~rx_sync;

    // Stop-bit sample of a frame holding the acknowledgement value.
    assign ack_hit = (rx_state == R_STOP) && (rx_cnt == '0) && rx_sync &&
                     (rx_shift == ACK_BYTE);

    // Terminal count is held while a receive frame is in flight, so the
    // timeout only acts once that frame has resolved.
    assign timeout = (tmr == '0) && (rx_state == R_HUNT);

    assign bus.ready    = (state == S_IDLE);
    assign bus.done     = done_q;
    assign bus.fail     = fail_q;
    assign bus.attempts = attempts_q;
    assign tx           = tx_q;

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state      <= S_IDLE;
            send_r     <= 1'b0;
            data_r     <= '0;
            data_lat   <= '0;
            tx_shift   <= '0;
            tx_cnt     <= '0;
            tx_bit     <= '0;
            tx_q       <= 1'b1;
            tmr        <= '0;
            attempts_q <= '0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            fail_q <= 1'b0;

            // Request is registered first; the frame starts one cycle later.
            // Qualifying with IDLE keeps a busy-time strobe from leaking
            // into the next IDLE cycle.
            send_r <= bus.send && (state == S_IDLE);
            if (bus.send && (state == S_IDLE)) begin
                data_r <= bus.data_in;
            end

            case (state)
                S_IDLE: begin
                    if (send_r) begin
                        data_lat   <= data_r;
                        tx_shift   <= data_r;
                        attempts_q <= ATT_ONE;
                        tx_q       <= 1'b0;
                        tx_cnt     <= BAUD_LOAD;
                        state      <= S_TX_START;
                    end
                end

                S_TX_START: begin
                    if (tx_cnt == '0) begin
                        tx_q   <= tx_shift[0];
                        tx_bit <= '0;
                        tx_cnt <= BAUD_LOAD;
                        state  <= S_TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end
                end

                S_TX_DATA: begin
                    if (tx_cnt == '0) begin
                        tx_cnt <= BAUD_LOAD;
                        if (tx_bit == LAST_BIT) begin
                            tx_q  <= 1'b1;
                            state <= S_TX_STOP;
                        end else begin
                            tx_q     <= tx_shift[1];
                            tx_shift <= tx_shift >> 1;
                            tx_bit   <= tx_bit + 1'b1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end
                end

                S_TX_STOP: begin
                    if (tx_cnt == '0) begin
                        tmr   <= TMR_LOAD;
                        state <= S_WAIT_ACK;
                    end else begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end
                end

                S_WAIT_ACK: begin
                    if (tmr != '0) begin
                        tmr <= tmr - 1'b1;
                    end
                    if (ack_hit) begin
                        done_q <= 1'b1;
                        state  <= S_IDLE;
                    end else if (timeout) begin
                        if (attempts_q == ATT_MAX) begin
                            fail_q <= 1'b1;
                            state  <= S_IDLE;
                        end else begin
                            attempts_q <= attempts_q + 1'b1;
                            tx_shift   <= data_lat;
                            tx_q       <= 1'b0;
                            tx_cnt     <= BAUD_LOAD;
                            state      <= S_TX_START;
                        end
                    end
                end

                default: begin
                    tx_q  <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Acknowledgement receiver. Only the synchronised copy of rx is used;
    // outside WAIT_ACK the receiver is parked in HUNT.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= R_HUNT;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;

            if (state != S_WAIT_ACK) begin
                rx_state <= R_HUNT;
                rx_cnt   <= '0;
                rx_bit   <= '0;
            end else begin
                case (rx_state)
                    R_HUNT: begin
                        if (rx_fall) begin
                            rx_cnt   <= HALF_LOAD;
                            rx_state <= R_START;
                        end
                    end

                    R_START: begin
                        if (rx_cnt == '0) begin
                            if (rx_sync) begin
                                rx_state <= R_HUNT;
                            end else begin
                                rx_cnt   <= BAUD_LOAD;
                                rx_bit   <= '0;
                                rx_state <= R_DATA;
                            end
                        end else begin
                            rx_cnt <= rx_cnt - 1'b1;
                        end
                    end

                    R_DATA: begin
                        if (rx_cnt == '0) begin
                            rx_shift <= {rx_sync, rx_shift[UART_WIDTH-1:1]};
                            rx_cnt   <= BAUD_LOAD;
                            if (rx_bit == LAST_BIT) begin
                                rx_state <= R_STOP;
                            end else begin
                                rx_bit <= rx_bit + 1'b1;
                            end
                        end else begin
                            rx_cnt <= rx_cnt - 1'b1;
                        end
                    end

                    R_STOP: begin
                        // Good or framing error, the frame is finished here;
                        // the main FSM has already acted on a matching byte.
                        if (rx_cnt == '0) begin
                            rx_state <= R_HUNT;
                        end else begin
                            rx_cnt <= rx_cnt - 1'b1;
                        end
                    end

                    default: rx_state <= R_HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_ack_sender.sv
// tb_uart_ack_sender
// Directed bench for uart_ack_sender with scaled timing: 1 MHz clock and
// 50 kbaud give 20 cycles per bit and a 1000-cycle acknowledgement window.
module tb_uart_ack_sender;

    localparam int BD    = 20;
    localparam int TO    = 1000;
    localparam int FRAME = 10 * BD;
    localparam logic [7:0] ACK = 8'hCC;

    logic clk = 1'b0;
    logic rst_n;
    logic tx;
    logic rx;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int rst_evt = 0;

    logic [7:0] exp_q[$];
    int         starts[$];

    int         done_cnt = 0;
    int         fail_cnt = 0;
    int         both_cnt = 0;
    int         done_cyc = 0;
    int         fail_cyc = 0;
    logic       done_rdy;
    logic       fail_rdy;
    logic [2:0] done_att;
    logic [2:0] fail_att;

    uart_ack_sender_if #(.UART_WIDTH(8), .ATT_W(3)) u_if ();

    uart_ack_sender #(
        .CLK_FREQ        (1_000_000),
        .BAUD_RATE       (50_000),
        .UART_WIDTH      (8),
        .RETRANSMIT_COUNT(5),
        .ACK_TIMEOUT     (1),
        .ACK_BYTE        (8'b11001100)
    ) dut (
        .clk (clk),
        .rstN(rst_n),
        .bus (u_if),
        .tx  (tx),
        .rx  (rx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) rst_evt <= rst_evt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int last_start();
        return (starts.size() > 0) ? starts[starts.size()-1] : cyc;
    endfunction

    // tx frame decoder: mid-bit sampling plus every cycle of every bit must
    // agree with its mid-bit value. Decoded bytes are matched to exp_q.
    initial begin : tx_mon
        logic [9:0] bits;
        logic       samp [FRAME];
        logic       shape_ok;
        int         s;
        int         r0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                s = cyc;
                r0 = rst_evt;
                starts.push_back(s);
                bits = '0;
                for (int c = 0; c < FRAME; c++) begin
                    if (c > 0) @(negedge clk);
                    samp[c] = tx;
                    if ((c % BD) == BD / 2) bits[c / BD] = tx;
                end
                if (rst_evt != r0) begin
                    void'(starts.pop_back());
                end else begin
                    shape_ok = 1'b1;
                    for (int c = 0; c < FRAME; c++)
                        if (samp[c] !== bits[c / BD]) shape_ok = 1'b0;
                    check("frame_shape", {29'd0, shape_ok, bits[0], bits[9]}, 32'd5);
                    check("frame_expected", (exp_q.size() > 0) ? 1 : 0, 1);
                    if (exp_q.size() > 0) check("frame_byte", bits[8:1], exp_q.pop_front());
                end
            end
        end
    end

    initial begin : evt_mon
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (u_if.done === 1'b1) begin
                    done_cyc = cyc; done_rdy = u_if.ready; done_att = u_if.attempts;
                    done_cnt++;
                end
                if (u_if.fail === 1'b1) begin
                    fail_cyc = cyc; fail_rdy = u_if.ready; fail_att = u_if.attempts;
                    fail_cnt++;
                end
                if (u_if.done === 1'b1 && u_if.fail === 1'b1) both_cnt++;
            end
        end
    end

    initial begin : watchdog
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: run did not reach its summary within 60000 cycles");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_starts(input int n, input int budget, input string tag);
        int k = 0;
        while (starts.size() < n && k < budget) begin @(negedge clk); k++; end
        check(tag, starts.size(), n);
    endtask

    task automatic wait_evt(input bit is_fail, input int prev, input int budget, input string tag);
        int k = 0;
        while (((is_fail ? fail_cnt : done_cnt) == prev) && k < budget) begin
            @(negedge clk); k++;
        end
        check(tag, (is_fail ? fail_cnt : done_cnt) - prev, 1);
    endtask

    task automatic do_send(input logic [7:0] b, output int acc);
        int k = 0;
        @(negedge clk);
        while (u_if.ready !== 1'b1 && k < 10000) begin @(negedge clk); k++; end
        u_if.data_in = b;
        u_if.send = 1'b1;
        @(negedge clk);
        acc = cyc;
        u_if.send = 1'b0;
        check("ready_in_accept_cycle", u_if.ready, 1);
        @(negedge clk);
        check("ready_after_accept", u_if.ready, 0);
        check("tx_start_edge", tx, 0);
    endtask

    task automatic rx_byte(input logic [7:0] b, output int t0);
        @(negedge clk);
        t0 = cyc;
        rx = 1'b0;
        repeat (BD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BD) @(negedge clk);
        end
        rx = 1'b1;
        repeat (BD) @(negedge clk);
    endtask

    // Two sync flops, then HALF (10) to the start resample and 9 bit times
    // to the stop sample; done shows in the following cycle.
    function automatic int ack_done_cyc(input int t0);
        return t0 + 3 + BD / 2 + 9 * BD;
    endfunction

    initial begin : main
        int acc, t0, base, d0, f0, s1;

        rst_n = 1'b0;
        rx = 1'b1;
        u_if.send = 1'b0;
        u_if.data_in = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_ready", u_if.ready, 1);
        check("rst_done", u_if.done, 0);
        check("rst_fail", u_if.fail, 0);
        check("rst_attempts", u_if.attempts, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 0xA5 acknowledged 100 cycles after the stop bit
        base = starts.size(); d0 = done_cnt;
        exp_q.push_back(8'hA5);
        do_send(8'hA5, acc);
        wait_starts(base + 1, 10, "t1_start");
        check("t1_start_cycle", last_start(), acc + 1);
        s1 = last_start();
        wait_until(s1 + FRAME + 100);
        rx_byte(ACK, t0);
        wait_evt(1'b0, d0, 400, "t1_done");
        check("t1_done_cycle", done_cyc, ack_done_cyc(t0));
        check("t1_done_ready", done_rdy, 1);
        check("t1_attempts", done_att, 1);
        repeat (FRAME + TO) @(negedge clk);
        check("t1_frames", starts.size() - base, 1);

        // 0x3C never acknowledged: six frames then fail
        base = starts.size(); d0 = done_cnt; f0 = fail_cnt;
        repeat (6) exp_q.push_back(8'h3C);
        do_send(8'h3C, acc);
        wait_evt(1'b1, f0, 6 * (FRAME + TO) + 400, "t2_fail");
        check("t2_frames", starts.size() - base, 6);
        for (int i = 1; i < 6; i++)
            if (starts.size() > base + i)
                check("t2_spacing", starts[base + i] - starts[base + i - 1], FRAME + TO);
        check("t2_fail_cycle", fail_cyc, acc + 1 + 6 * (FRAME + TO));
        check("t2_fail_ready", fail_rdy, 1);
        check("t2_fail_attempts", fail_att, 6);
        check("t2_no_done", done_cnt - d0, 0);
        repeat (50) @(negedge clk);
        check("t2_attempts_hold", u_if.attempts, 6);
        check("t2_no_more_frames", starts.size() - base, 6);

        // 0x10: wrong byte 0x3B first, then the acknowledgement
        base = starts.size(); d0 = done_cnt;
        exp_q.push_back(8'h10);
        do_send(8'h10, acc);
        wait_until(acc + 1 + FRAME + 50);
        rx_byte(8'h3B, t0);
        repeat (10) @(negedge clk);
        check("t3_wrong_byte_ignored", done_cnt - d0, 0);
        rx_byte(ACK, t0);
        wait_evt(1'b0, d0, 400, "t3_done");
        check("t3_done_cycle", done_cyc, ack_done_cyc(t0));
        check("t3_attempts", done_att, 1);
        repeat (FRAME + TO) @(negedge clk);
        check("t3_frames", starts.size() - base, 1);

        // 0x7E acknowledged after the second timeout; data_in changed
        base = starts.size(); d0 = done_cnt;
        repeat (3) exp_q.push_back(8'h7E);
        do_send(8'h7E, acc);
        u_if.data_in = 8'h00;
        wait_starts(base + 3, 3 * (FRAME + TO) + 400, "t4_three_frames");
        wait_until(last_start() + FRAME + 50);
        rx_byte(ACK, t0);
        wait_evt(1'b0, d0, 400, "t4_done");
        check("t4_attempts", done_att, 3);
        repeat (FRAME + TO) @(negedge clk);
        check("t4_frames", starts.size() - base, 3);

        // reset in the middle of TX_DATA, after a send pulsed while busy
        base = starts.size(); d0 = done_cnt; f0 = fail_cnt;
        do_send(8'h55, acc);
        repeat (5) @(negedge clk);
        u_if.data_in = 8'h81;
        u_if.send = 1'b1;
        check("t5_busy_ready", u_if.ready, 0);
        @(negedge clk);
        u_if.send = 1'b0;
        wait_until(acc + 1 + 3 * BD + 5);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t5_rst_tx", tx, 1);
        check("t5_rst_ready", u_if.ready, 1);
        check("t5_rst_attempts", u_if.attempts, 0);
        check("t5_rst_pulses", {30'd0, u_if.done, u_if.fail}, 0);
        repeat (2 * (FRAME + TO)) @(negedge clk);
        check("t5_no_frames", starts.size() - base, 0);
        check("t5_no_pulses", (done_cnt - d0) + (fail_cnt - f0), 0);
        check("t5_tx_idle", tx, 1);

        // short low glitch in WAIT_ACK: rejected, retransmit on schedule
        base = starts.size(); d0 = done_cnt;
        repeat (2) exp_q.push_back(8'h99);
        do_send(8'h99, acc);
        wait_until(acc + 1 + FRAME + 100);
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        wait_starts(base + 2, FRAME + TO + 200, "t6_retransmit");
        if (starts.size() >= base + 2)
            check("t6_spacing", starts[base + 1] - starts[base], FRAME + TO);
        check("t6_no_done_yet", done_cnt - d0, 0);
        wait_until(last_start() + FRAME + 50);
        rx_byte(ACK, t0);
        wait_evt(1'b0, d0, 400, "t6_done");
        check("t6_attempts", done_att, 2);

        // acknowledgement straddling the timeout: deferred, ACK wins
        base = starts.size(); d0 = done_cnt;
        exp_q.push_back(8'h42);
        do_send(8'h42, acc);
        wait_until(acc + 1 + FRAME + TO - 100);
        rx_byte(ACK, t0);
        wait_evt(1'b0, d0, 400, "t7_done");
        check("t7_done_cycle", done_cyc, ack_done_cyc(t0));
        check("t7_attempts", done_att, 1);
        repeat (FRAME + TO) @(negedge clk);
        check("t7_frames", starts.size() - base, 1);

        check("done_fail_exclusive", both_cnt, 0);
        check("all_frames_seen", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
